// File: rtl/parking_gate_controller_pkg.sv
// Shared definitions for the parking gate controller: slot count, widths,
// FSM state codes and arbitration direction codes.
package parking_gate_controller_pkg;

    localparam int NUM_SLOTS   = 4;
    localparam int OPEN_CYCLES = 3;
    localparam int SLOT_W      = 2;   // index width into the slot register
    localparam int CAP_W       = 3;   // holds 0..NUM_SLOTS

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OPEN_IN  = 2'd1,
        ST_OPEN_OUT = 2'd2,
        ST_CLOSING  = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_ENTRY = 1'b0,
        GRANT_EXIT  = 1'b1
    } grant_t;

endpackage

// File: rtl/parking_gate_controller_slot_allocator.sv
// Combinational view of the occupancy register: free-slot count,
// 1-based index of the lowest free slot (0 when none) and full flag.
module slot_allocator
    import parking_gate_controller_pkg::*;
(
    input  logic [NUM_SLOTS-1:0] i_slots,
    output logic [CAP_W-1:0]     o_capacity,
    output logic [CAP_W-1:0]     o_best_place,
    output logic                 o_full
);

    logic [CAP_W-1:0] w_free_cnt;
    logic [CAP_W-1:0] w_best;

    // Popcount of free bits; scanning high-to-low leaves the lowest free index.
    always_comb begin
        w_free_cnt = '0;
        w_best     = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!i_slots[i]) begin
                w_free_cnt = w_free_cnt + CAP_W'(1);
                w_best     = CAP_W'(i + 1);
            end
        end
    end

    assign o_capacity   = w_free_cnt;
    assign o_best_place = w_best;
    assign o_full       = (w_free_cnt == '0);

endmodule

// File: rtl/parking_gate_controller.sv
// Shared parking gate sequencer: edge-detects the entry/exit sensors, holds
// one pending request per direction, arbitrates, times the door window and
// owns the slot occupancy register.
//
//  state       | meaning
//  ------------+--------------------------------------------------
//  ST_IDLE     | door closed, arbitrate pending requests
//  ST_OPEN_IN  | door open for an admitted car, timer counting down
//  ST_OPEN_OUT | door open for a departing car, timer counting down
//  ST_CLOSING  | one dead cycle with door closed before next grant
module parking_gate_controller
    import parking_gate_controller_pkg::*;
#(
    parameter int OPEN_CYCLES_P = OPEN_CYCLES
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_entry_sensor,
    input  logic                 i_exit_sensor,
    input  logic [SLOT_W-1:0]    i_switch,
    output logic [NUM_SLOTS-1:0] o_parking_slots,
    output logic                 o_door_open_light,
    output logic                 o_full_light,
    output logic [CAP_W-1:0]     o_capacity,
    output logic [CAP_W-1:0]     o_best_place,
    output logic                 o_reject
);

    localparam int TIMER_W = (OPEN_CYCLES_P > 1) ? $clog2(OPEN_CYCLES_P) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(OPEN_CYCLES_P - 1);

    state_t                r_state, w_state_nxt;
    grant_t                r_last_grant, w_last_nxt;
    logic [NUM_SLOTS-1:0]  r_slots, w_slots_nxt;
    logic [TIMER_W-1:0]    r_timer, w_timer_nxt;
    logic                  r_door, w_door_nxt;
    logic                  r_reject, w_reject_nxt;
    logic                  r_prev_entry, r_prev_exit;
    logic                  r_pend_entry, r_pend_exit;
    logic [SLOT_W-1:0]     r_exit_slot;

    logic                  w_entry_edge, w_exit_edge;
    logic                  w_clr_entry, w_clr_exit;
    logic                  w_pick_exit;
    logic                  w_full;
    logic [CAP_W-1:0]      w_capacity, w_best_place;
    logic [SLOT_W-1:0]     w_best_idx;

    slot_allocator u_slot_allocator (
        .i_slots      (r_slots),
        .o_capacity   (w_capacity),
        .o_best_place (w_best_place),
        .o_full       (w_full)
    );

    assign w_entry_edge = i_entry_sensor & ~r_prev_entry;
    assign w_exit_edge  = i_exit_sensor  & ~r_prev_exit;
    assign w_best_idx   = SLOT_W'(w_best_place - CAP_W'(1));

    // Sensor history and one-deep pending requests; an edge arriving while
    // its direction is already pending is dropped.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev_entry <= 1'b0;
            r_prev_exit  <= 1'b0;
            r_pend_entry <= 1'b0;
            r_pend_exit  <= 1'b0;
            r_exit_slot  <= '0;
        end else begin
            r_prev_entry <= i_entry_sensor;
            r_prev_exit  <= i_exit_sensor;
            if (w_entry_edge && !r_pend_entry)
                r_pend_entry <= 1'b1;
            else if (w_clr_entry)
                r_pend_entry <= 1'b0;
            if (w_exit_edge && !r_pend_exit) begin
                r_pend_exit <= 1'b1;
                r_exit_slot <= i_switch;
            end else if (w_clr_exit) begin
                r_pend_exit <= 1'b0;
            end
        end
    end

    // State, timer, occupancy and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= GRANT_ENTRY;
            r_slots      <= '0;
            r_timer      <= '0;
            r_door       <= 1'b0;
            r_reject     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_nxt;
            r_slots      <= w_slots_nxt;
            r_timer      <= w_timer_nxt;
            r_door       <= w_door_nxt;
            r_reject     <= w_reject_nxt;
        end
    end

    // Arbitration, grant/reject decisions and door timing.
    always_comb begin
        w_state_nxt  = r_state;
        w_last_nxt   = r_last_grant;
        w_slots_nxt  = r_slots;
        w_timer_nxt  = r_timer;
        w_door_nxt   = r_door;
        w_reject_nxt = 1'b0;
        w_clr_entry  = 1'b0;
        w_clr_exit   = 1'b0;
        w_pick_exit  = 1'b0;

        // When full an exit is the only request that can make progress.
        if (r_pend_entry && r_pend_exit)
            w_pick_exit = w_full ? 1'b1 : (r_last_grant == GRANT_ENTRY);
        else
            w_pick_exit = r_pend_exit;

        case (r_state)
            ST_IDLE: begin
                w_door_nxt = 1'b0;
                if (r_pend_entry || r_pend_exit) begin
                    if (w_pick_exit) begin
                        w_clr_exit = 1'b1;
                        if (r_slots[r_exit_slot]) begin
                            w_slots_nxt[r_exit_slot] = 1'b0;
                            w_state_nxt = ST_OPEN_OUT;
                            w_door_nxt  = 1'b1;
                            w_timer_nxt = TIMER_LOAD;
                            w_last_nxt  = GRANT_EXIT;
                        end else begin
                            w_reject_nxt = 1'b1;
                        end
                    end else begin
                        w_clr_entry = 1'b1;
                        if (!w_full) begin
                            w_slots_nxt[w_best_idx] = 1'b1;
                            w_state_nxt = ST_OPEN_IN;
                            w_door_nxt  = 1'b1;
                            w_timer_nxt = TIMER_LOAD;
                            w_last_nxt  = GRANT_ENTRY;
                        end else begin
                            w_reject_nxt = 1'b1;
                        end
                    end
                end
            end
            ST_OPEN_IN, ST_OPEN_OUT: begin
                if (r_timer == '0) begin
                    w_state_nxt = ST_CLOSING;
                    w_door_nxt  = 1'b0;
                end else begin
                    w_timer_nxt = r_timer - TIMER_W'(1);
                end
            end
            ST_CLOSING: begin
                w_door_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_door_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_parking_slots   = r_slots;
    assign o_door_open_light = r_door;
    assign o_full_light      = w_full;
    assign o_capacity        = w_capacity;
    assign o_best_place      = w_best_place;
    assign o_reject          = r_reject;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed bench for parking_gate_controller with hand-computed expectations.
module tb_parking_gate_controller;

    logic       clk;
    logic       rst;
    logic       entry_sensor;
    logic       exit_sensor;
    logic [1:0] sw;
    logic [3:0] parking_slots;
    logic       door_open_light;
    logic       full_light;
    logic [2:0] capacity;
    logic [2:0] best_place;
    logic       reject;

    int n_asserts = 0;
    int n_fail    = 0;

    parking_gate_controller dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_entry_sensor    (entry_sensor),
        .i_exit_sensor     (exit_sensor),
        .i_switch          (sw),
        .o_parking_slots   (parking_slots),
        .o_door_open_light (door_open_light),
        .o_full_light      (full_light),
        .o_capacity        (capacity),
        .o_best_place      (best_place),
        .o_reject          (reject)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asserts++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after the edge that latched a request: checks the grant
    // edge, the three open cycles and the closing cycle, ends in IDLE.
    task automatic serve(input string tag, input logic [3:0] exp_slots);
        tick();
        check_eq({tag, " slots"}, 8'(parking_slots), 8'(exp_slots));
        check_eq({tag, " door1"}, 8'(door_open_light), 8'd1);
        tick();
        check_eq({tag, " door2"}, 8'(door_open_light), 8'd1);
        tick();
        check_eq({tag, " door3"}, 8'(door_open_light), 8'd1);
        tick();
        check_eq({tag, " closing"}, 8'(door_open_light), 8'd0);
        tick();
    endtask

    task automatic check_reject(input string tag, input logic [3:0] exp_slots);
        tick();
        check_eq({tag, " rej"}, 8'(reject), 8'd1);
        check_eq({tag, " door"}, 8'(door_open_light), 8'd0);
        check_eq({tag, " slots"}, 8'(parking_slots), 8'(exp_slots));
        tick();
        check_eq({tag, " rej_low"}, 8'(reject), 8'd0);
    endtask

    initial begin
        logic [3:0] exp_fill [4];
        logic [3:0] exp_drain [4];
        exp_fill  = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
        exp_drain = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};

        rst = 1'b1; entry_sensor = 1'b0; exit_sensor = 1'b0; sw = 2'd0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // 1: reset state
        check_eq("rst slots", 8'(parking_slots), 8'd0);
        check_eq("rst cap", 8'(capacity), 8'd4);
        check_eq("rst best", 8'(best_place), 8'd1);
        check_eq("rst door", 8'(door_open_light), 8'd0);
        check_eq("rst full", 8'(full_light), 8'd0);
        check_eq("rst rej", 8'(reject), 8'd0);

        // 2: fill all four slots
        for (int i = 0; i < 4; i++) begin
            entry_sensor = 1'b1;
            tick();
            entry_sensor = 1'b0;
            serve($sformatf("fill%0d", i), exp_fill[i]);
        end
        check_eq("full cap", 8'(capacity), 8'd0);
        check_eq("full best", 8'(best_place), 8'd0);
        check_eq("full light", 8'(full_light), 8'd1);

        // 3: fifth entry refused
        entry_sensor = 1'b1;
        tick();
        entry_sensor = 1'b0;
        check_reject("full_entry", 4'b1111);

        // 4: simultaneous entry and exit while full: exit first
        entry_sensor = 1'b1; exit_sensor = 1'b1; sw = 2'd2;
        tick();
        entry_sensor = 1'b0; exit_sensor = 1'b0;
        serve("both_exit", 4'b1011);
        serve("both_entry", 4'b1111);

        // drain slots 0..3
        for (int i = 0; i < 4; i++) begin
            exit_sensor = 1'b1; sw = 2'(i);
            tick();
            exit_sensor = 1'b0;
            serve($sformatf("drain%0d", i), exp_drain[i]);
        end
        check_eq("empty cap", 8'(capacity), 8'd4);

        // 5: exit of an empty slot
        exit_sensor = 1'b1; sw = 2'd1;
        tick();
        exit_sensor = 1'b0;
        check_reject("empty_exit", 4'b0000);

        // reject must not move last_grant: entry grant, then a rejected exit,
        // then a tie which must go to exit
        entry_sensor = 1'b1;
        tick();
        entry_sensor = 1'b0;
        serve("rr_entry", 4'b0001);
        exit_sensor = 1'b1; sw = 2'd1;
        tick();
        exit_sensor = 1'b0;
        check_reject("rr_rej", 4'b0001);
        entry_sensor = 1'b1; exit_sensor = 1'b1; sw = 2'd0;
        tick();
        entry_sensor = 1'b0; exit_sensor = 1'b0;
        serve("rr_tie_exit", 4'b0000);
        serve("rr_tie_entry", 4'b0001);
        check_eq("rr cap", 8'(capacity), 8'd3);
        check_eq("rr best", 8'(best_place), 8'd2);

        // 6: reset while the door is open
        entry_sensor = 1'b1;
        tick();
        entry_sensor = 1'b0;
        tick();
        check_eq("pre_rst door", 8'(door_open_light), 8'd1);
        check_eq("pre_rst slots", 8'(parking_slots), 8'b0011);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst door", 8'(door_open_light), 8'd0);
        check_eq("mid_rst slots", 8'(parking_slots), 8'd0);
        check_eq("mid_rst cap", 8'(capacity), 8'd4);
        check_eq("mid_rst best", 8'(best_place), 8'd1);
        check_eq("mid_rst full", 8'(full_light), 8'd0);
        check_eq("mid_rst rej", 8'(reject), 8'd0);
        tick();
        rst = 1'b0;
        tick(); tick();
        check_eq("post_rst door", 8'(door_open_light), 8'd0);
        check_eq("post_rst slots", 8'(parking_slots), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
